pla_restriction_sweeper: RTL
============================

# pla_restriction_sweeper

Sequential stimulus/response stage wrapped around one combinational single-output benchmark function (16 inputs `x0..x15`, output `y0`). It drives the function's inputs and captures its output. It enumerates every input vector of a restriction, meaning a subset of inputs is fixed to constants and the remaining free inputs are swept exhaustively. It then reports the on-set size and a CRC signature of the output stream, so restricted netlists can be checked against their unrestricted parent.

## Interface
Parameters:
- `DUT_LAT`, default 0: register stages inside the function under test; 0 means purely combinational.
- `SIG_SEED`, default 16'hFFFF: signature register value loaded at start.

Ports:
- Reset is asynchronous and active-low.
- `clk` input, 1 bit: single clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `start` input, 1 bit: one-cycle request; honoured only in IDLE.
- `fix_mask` input, 16 bits: 1 means the input is fixed; sampled at start.
- `fix_val` input, 16 bits: constant values for fixed inputs; sampled at start.
- `x` output, 16 bits: registered vector to the function; bit i drives `xi`.
- `x_valid` output, 1 bit: `x` carries a sweep vector this cycle.
- `y` input, 1 bit: the function's output `y0`.
- `busy` output, 1 bit: sweep in progress.
- `done` output, 1 bit: one-cycle pulse when results are final.
- `onset_count` output, 17 bits: number of vectors with `y`=1.
- `signature` output, 16 bits: CRC over the captured `y` stream.

## Operation
- States:
  - IDLE: on `start`, latch `fix_mask` and `fix_val`, compute F = popcount(~fix_mask), clear the counter and `onset_count`, load `signature` with `SIG_SEED`, then go to RUN.
  - RUN: one vector per cycle; after vector N-1 (N = 2^F), go to DRAIN.
  - DRAIN: held for exactly DUT_LAT+1 cycles, then go to DONE.
  - DONE: pulse `done` for one cycle, return to IDLE.
- Vector k (k = 0..N-1):
  - Free input positions, in ascending bit order, receive k[0], k[1], … (bit deposit).
  - Fixed positions receive `fix_val`.
  - `fix_val` bits at free positions are ignored.
- Index counter is 17 bits so that F=16 (N=65536) terminates without wrap ambiguity.
- Capture:
  - A valid delay line of depth DUT_LAT+1 tags each sample.
  - On each tagged edge, `onset_count` += `y`.
  - `signature` updates as: fb = signature[15]^y; signature = {signature[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- `onset_count` range is 0..65536 with no saturation needed; the 17 bits suffice.
- `start` outside IDLE is ignored. The latched mask and value cannot change mid-sweep.
- Results hold from DONE until the next accepted `start`.
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, `onset_count`=0, `signature`=0, state IDLE, delay line cleared.
- Reset mid-sweep aborts immediately to the reset values. No `done` is produced.

## Timing
- `start` is sampled at edge E. Vector k appears on `x` with `x_valid`=1 after edge E+k.
- `y` for vector k is sampled at edge E+k+1+DUT_LAT.
- `busy` is high from after E until `done` rises.
- `done` is high for the single cycle after edge E+N+1+DUT_LAT. The final `onset_count` and `signature` are visible that same cycle.
- `x_valid` is low and `x` holds its last vector outside RUN.
- Back-to-back operation: a `start` sampled in the `done` cycle is ignored (state is DONE). It is accepted from the next cycle.
- F=0 (`fix_mask`=16'hFFFF): exactly one vector, `x`=`fix_val`; `done` follows 2+DUT_LAT cycles after E.

## Structure
- Package `pla_sweep_pkg` holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - `CRC_POLY`=16'h1021;
  - `NIN`=16 and `CNT_W`=17.
- Sub-module `bit_deposit` (combinational, 16-bit): output bit i = mask_free[i] ? cnt[popcount(mask_free[i-1:0])] : 0. The top level ORs in `fix_val & fix_mask`.
- The top level holds the FSM, counter, delay line, onset counter and CRC register. Target is about 200 lines.

## Test plan
- Stub y = x0 & x1, `fix_mask`=16'hFFFC, `fix_val`=0, DUT_LAT=0 → `x` = 0,1,2,3; `onset_count`=1; `done` one cycle after edge E+5.
- Scatter check: `fix_mask`=16'hFF7E, `fix_val`=16'h8000 → `x` = 8000, 8001, 8080, 8081.
- Full sweep: `fix_mask`=0, stub y=1 → N=65536; `onset_count`=65536 (17'h10000); no early termination.
- F=0, stub y=1, `fix_val`=16'h1234 → one vector 16'h1234; `onset_count`=1; `signature` equals one CRC step of y=1 from `SIG_SEED`.
- DUT_LAT=2 with a registered stub → same counts and signature as DUT_LAT=0; `done` delayed 2 cycles.
- Reset mid-RUN at k=3, then `start` asserted during RUN (before the reset) → the `start` is ignored; after reset all outputs are 0 and no `done` is produced.

Source files
------------

// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the restriction sweeper.
package pla_sweep_pkg;

    localparam int unsigned NIN   = 16;
    localparam int unsigned CNT_W = 17;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [4:0] popcount(input logic [NIN-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] sig, input logic b);
        logic fb;
        fb = sig[15] ^ b;
        return {sig[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bit_deposit.sv
// Scatters the low counter bits onto the free positions of a mask, lowest bit first.
module bit_deposit
    import pla_sweep_pkg::*;
(
    input  logic [NIN-1:0] mask_free,
    input  logic [NIN-1:0] cnt,
    output logic [NIN-1:0] deposit
);

    logic [4:0] j;

    always_comb begin
        deposit = '0;
        j       = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            if (mask_free[i]) begin
                deposit[i] = cnt[j[3:0]];
                j          = j + 5'd1;
            end
        end
    end

endmodule

// File: rtl/pla_restriction_sweeper.sv
// Sweeps every vector of a restriction through a single-output function and
// reports its on-set size and a CRC signature of the response stream.
module pla_restriction_sweeper
    import pla_sweep_pkg::*;
#(
    parameter int unsigned DUT_LAT  = 0,
    parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NIN-1:0]   fix_mask,
    input  logic [NIN-1:0]   fix_val,
    output logic [NIN-1:0]   x,
    output logic             x_valid,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_count,
    output logic [15:0]      signature
);

    localparam int unsigned DW = $clog2(DUT_LAT + 2);

    state_t           state;
    logic [NIN-1:0]   mask_q;
    logic [NIN-1:0]   val_q;
    logic [NIN-1:0]   free_q;
    logic [NIN-1:0]   dep;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_total;
    logic [DW-1:0]    dcnt;
    logic [DUT_LAT:0] vline;

    assign free_q  = ~mask_q;
    assign x_valid = vline[0];

    bit_deposit u_deposit (
        .mask_free (free_q),
        .cnt       (cnt[NIN-1:0]),
        .deposit   (dep)
    );

    // vline[0] is x_valid itself; vline[DUT_LAT] marks the edge where y belongs to a vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            val_q       <= '0;
            cnt         <= '0;
            n_total     <= '0;
            dcnt        <= '0;
            vline       <= '0;
            x           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            onset_count <= '0;
            signature   <= '0;
        end else begin
            vline <= vline << 1;
            if (vline[DUT_LAT]) begin
                onset_count <= onset_count + CNT_W'(y);
                signature   <= crc_step(signature, y);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q      <= fix_mask;
                        val_q       <= fix_val;
                        n_total     <= CNT_W'(1) << popcount(~fix_mask);
                        cnt         <= CNT_W'(1);
                        onset_count <= '0;
                        signature   <= SIG_SEED;
                        // vector 0 deposits nothing, so only the fixed bits remain
                        x           <= fix_val & fix_mask;
                        vline[0]    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == n_total) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        x        <= dep | (val_q & mask_q);
                        cnt      <= cnt + CNT_W'(1);
                        vline[0] <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DUT_LAT)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
